// File: rtl/hazard_stall_controller.sv
// Hazard stall controller: load-use, branch-in-ID and HI/LO busy
// stalls, plus the IF/ID flush for taken branches.
//
// Ports:
//   Clk, Rst                    clock, async active-high reset
//   IDU_*                       ID-stage operands and decode flags
//   EXU_*                       EX-stage load/writeback info
//   MEM_*                       MEM-stage load info
//   PC_Write, IFID_Write        pipeline write enables
//   IDEX_Bubble, IFID_Flush     bubble into ID/EX, clear IF/ID
//   MulDivBusy                  HI/LO unit occupied (registered)
//   StallCycles                 stall cycle counter, only present
//                               when HAZARD_STALL_CNT_EN is defined
module hazard_stall_controller #(
    parameter int MULDIV_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  IDU_RsReg,
    input  logic [4:0]  IDU_RtReg,
    input  logic        IDU_UsesRt,
    input  logic        IDU_Branch,
    input  logic        IDU_BranchTaken,
    input  logic        IDU_MulDiv,
    input  logic        IDU_HiLoUse,
    input  logic        EXU_MemRead,
    input  logic        EXU_RegWrite,
    input  logic [4:0]  EXU_DestinationRegAddress,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_DestinationRegAddress,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
`ifdef HAZARD_STALL_CNT_EN
    output logic        MulDivBusy,
    output logic [31:0] StallCycles
`else
    output logic        MulDivBusy
`endif
);

    localparam int CW = $clog2(MULDIV_LATENCY + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_haz;
    logic hilo_haz;
    logic stall;

    // r0 is hardwired zero, so it never creates a dependency.
    always_comb begin
        ex_match = 1'b0;
        mem_match = 1'b0;
        if (EXU_DestinationRegAddress != 5'd0) begin
            ex_match = (EXU_DestinationRegAddress == IDU_RsReg)
                    || (IDU_UsesRt
                        && EXU_DestinationRegAddress == IDU_RtReg);
        end
        if (MEM_DestinationRegAddress != 5'd0) begin
            mem_match = (MEM_DestinationRegAddress == IDU_RsReg)
                     || (IDU_UsesRt
                         && MEM_DestinationRegAddress == IDU_RtReg);
        end
    end

    assign MulDivBusy = (state_q == MD_BUSY);

    always_comb begin
        load_use = EXU_MemRead && EXU_RegWrite && ex_match;
        // Branches compare in ID, so even ALU results in EX and
        // load data still in MEM are too late for them.
        br_haz   = IDU_Branch
                && ((EXU_RegWrite && ex_match)
                    || (MEM_MemRead && mem_match));
        hilo_haz = MulDivBusy && IDU_HiLoUse;
        stall    = load_use || br_haz || hilo_haz;
    end

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        if (Rst) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
        end else if (stall) begin
            // A stalled branch must not flush until its
            // operands are valid and it resolves for real.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            IFID_Flush  = IDU_BranchTaken;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (IDU_MulDiv && !stall) begin
                    state_d = MD_BUSY;
                    cnt_d   = CW'(MULDIV_LATENCY - 1);
                end
            end
            MD_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;
`endif

endmodule
